// File: rtl/data_mem_pkg.sv
// Shared widths and access-size encodings for data_mem and the MEM-stage/decode logic.
// The optional alignment check is built when DATA_MEM_ALIGN_CHECK_EN is defined.
package data_mem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SIZE_8   = 2'b00,
    SIZE_16  = 2'b01,
    SIZE_32  = 2'b10,
    SIZE_ILL = 2'b11
  } mem_size_e;

  // Which of the four byte lanes an access of this size touches; the illegal code touches none.
  function automatic logic [3:0] size_lane_mask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      SIZE_8:  mask = 4'b0001;
      SIZE_16: mask = 4'b0011;
      SIZE_32: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_8:  mis = 1'b0;
      SIZE_16: mis = addr_lo[0];
      SIZE_32: mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_lane_dec.sv
// Maps an access size and low byte-address bits onto four byte lanes, each with a
// wrapped byte index into the array and a write enable.
module data_mem_lane_dec #(
  parameter int IDX_W = 8
) (
  input  logic [1:0]            i_size,
  input  logic [IDX_W-1:0]      i_addr,
  output logic [3:0][IDX_W-1:0] o_lane_idx,
  output logic [3:0]            o_lane_we
);
  import data_mem_pkg::*;

  // Lane k addresses byte a+k; the IDX_W-bit sum wraps at the top of memory for free.
  always_comb begin
    o_lane_idx = '0;
    for (int k = 0; k < 4; k++) begin
      o_lane_idx[k] = i_addr + IDX_W'(k);
    end
  end

  assign o_lane_we = size_lane_mask(i_size);

endmodule

// File: rtl/data_mem.sv
// Byte-addressable little-endian data memory: byte/half/word stores on the clock edge,
// combinational 32-bit word read. DATA_MEM_ALIGN_CHECK_EN adds o_misaligned and blocks misaligned stores.
module data_mem #(
  parameter int XLEN = 32,
  parameter int SIZE = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_write,
  input  logic [1:0]      i_size,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_data_in,
  output logic [XLEN-1:0] o_data_out
`ifdef DATA_MEM_ALIGN_CHECK_EN
  ,
  output logic            o_misaligned
`endif
);
  import data_mem_pkg::*;

  localparam int DEPTH = SIZE * 4;
  localparam int IDX_W = $clog2(DEPTH);

  logic [7:0]            r_mem [DEPTH];
  logic [3:0][IDX_W-1:0] w_lane_idx;
  logic [3:0]            w_lane_we;
  logic                  w_wr_en;
  logic                  w_unused_addr;

  // Upper address bits alias onto the same bytes.
  assign w_unused_addr = &{1'b0, i_addr[XLEN-1:IDX_W]};

  data_mem_lane_dec #(
    .IDX_W(IDX_W)
  ) u_lane_dec (
    .i_size     (i_size),
    .i_addr     (i_addr[IDX_W-1:0]),
    .o_lane_idx (w_lane_idx),
    .o_lane_we  (w_lane_we)
  );

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign o_misaligned = i_en & is_misaligned(i_size, i_addr[1:0]);
  assign w_wr_en      = i_en & i_write & ~o_misaligned;
`else
  assign w_wr_en      = i_en & i_write;
`endif

  // Reset wins over a coincident store; lanes of a single access never collide.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < DEPTH; b++) begin
        r_mem[b] <= 8'h00;
      end
    end else if (w_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (w_lane_we[k]) begin
          r_mem[w_lane_idx[k]] <= i_data_in[8*k +: 8];
        end
      end
    end
  end

  // No write-through bypass: a store becomes visible only after its edge.
  always_comb begin
    o_data_out = '0;
    if (i_en) begin
      for (int k = 0; k < 4; k++) begin
        o_data_out[8*k +: 8] = r_mem[w_lane_idx[k]];
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: stimulus pushes expected read-port values, a monitor pops and compares.
// Compile with DATA_MEM_ALIGN_CHECK_EN to also check o_misaligned and store suppression.
module tb_data_mem;

   typedef struct {
      logic [31:0] data;
      logic        mis;
      logic [31:0] addr;
      int          seq;
   } expT;

   logic        clk;
   logic        rst;
   logic        en;
   logic        write;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] dataIn;
   logic [31:0] dataOut;
`ifdef DATA_MEM_ALIGN_CHECK_EN
   logic        misaligned;
`endif

   logic [7:0]  modelMem [256];
   expT         sb [$];
   int          checkCount = 0;
   int          passCount = 0;
   int          seqNo = 0;

   data_mem #(.XLEN(32), .SIZE(64)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (en),
      .i_write      (write),
      .i_size       (size),
      .i_addr       (addr),
      .i_data_in    (dataIn),
      .o_data_out   (dataOut)
`ifdef DATA_MEM_ALIGN_CHECK_EN
      ,
      .o_misaligned (misaligned)
`endif
   );

   // Free-running clock with a 10-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: the word at addr is four consecutive bytes modulo the 256-byte array
   function automatic logic [31:0] modelLoad(input logic [31:0] a);
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         w[8*k +: 8] = modelMem[(int'(a % 256) + k) % 256];
      end
      return w;
   endfunction

   // How many bytes an access of this size code stores
   function automatic int bytesFor(input logic [1:0] s);
      if (s == 2'b00) return 1;
      if (s == 2'b01) return 2;
      if (s == 2'b10) return 4;
      return 0;
   endfunction

   // Misalignment rule: halfword needs even address, word needs multiple of four, code 3 is always bad
   function automatic logic modelMis(input logic e, input logic [1:0] s, input logic [31:0] a);
      int n;
      n = bytesFor(s);
      if (!e) return 1'b0;
      if (n == 0) return 1'b1;
      return (a % n) != 0;
   endfunction

   // Drive one cycle of inputs, record the expected read port, then update the model for the coming edge
   task automatic applyStimulus(input logic r, input logic e, input logic w, input logic [1:0] s,
                                input logic [31:0] a, input logic [31:0] d);
      expT x;
      int  n;
      @(posedge clk);
      #1;
      rst = r; en = e; write = w; size = s; addr = a; dataIn = d;
      x.data = e ? modelLoad(a) : 32'h0;
      x.mis  = modelMis(e, s, a);
      x.addr = a;
      x.seq  = seqNo;
      seqNo++;
      sb.push_back(x);
      if (r) begin
         for (int b = 0; b < 256; b++) modelMem[b] = 8'h00;
      end else if (e && w) begin
`ifdef DATA_MEM_ALIGN_CHECK_EN
         n = x.mis ? 0 : bytesFor(s);
`else
         n = bytesFor(s);
`endif
         for (int k = 0; k < n; k++) begin
            modelMem[(int'(a % 256) + k) % 256] = d[8*k +: 8];
         end
      end
   endtask

   task automatic load(input logic [31:0] a);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, a, $urandom);
   endtask

   task automatic store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      applyStimulus(1'b0, 1'b1, 1'b1, s, a, d);
   endtask

   // Compare the DUT read port against one scoreboard entry
   task automatic checkOutput(input expT x);
      checkCount++;
      if (dataOut !== x.data) begin
         $display("[TB] FAIL data_out seq=%0d addr=%h got %h expected %h", x.seq, x.addr, dataOut, x.data);
      end else begin
`ifdef DATA_MEM_ALIGN_CHECK_EN
         if (misaligned !== x.mis) begin
            $display("[TB] FAIL misaligned seq=%0d addr=%h got %b expected %b", x.seq, x.addr, misaligned, x.mis);
         end else begin
            passCount++;
         end
`else
         passCount++;
`endif
      end
   endtask

   // Monitor: every driven cycle presents a read-port value, sampled mid-cycle on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) checkOutput(sb.pop_front());
      end
   end

   // Hard stop if the run ever stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [1:0]  s;
      int          r;
      rst = 1'b0; en = 1'b0; write = 1'b0; size = 2'b00; addr = '0; dataIn = '0;
      for (int b = 0; b < 256; b++) modelMem[b] = 8'h00;

      // Reset then read
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      load(32'h10);

      // Word store/load, including an unaligned read
      store(2'b10, 32'h8, 32'hDEADBEEF);
      load(32'h8);
      load(32'h9);

      // Partial stores merging into one word
      store(2'b10, 32'h20, 32'h11223344);
      store(2'b00, 32'h21, 32'h000000AA);
      store(2'b01, 32'h22, 32'h00005566);
      load(32'h20);

      // Wrap at top of memory and address aliasing
      store(2'b10, 32'hFE, 32'hCAFEF00D);
      load(32'hFE);
      load(32'h0);
      load(32'h100);

      // Gating: disabled store, illegal size, disabled read
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 32'h30, 32'h12345678);
      load(32'h30);
      store(2'b11, 32'h8, 32'h01020304);
      load(32'h8);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 32'h8, 32'h0);

      // Read-during-write shows old data, then new
      store(2'b10, 32'h40, 32'hA5A5A5A5);
      store(2'b10, 32'h40, 32'h5A5A5A5A);
      load(32'h40);

      // Misaligned store (suppressed only with the alignment check)
      store(2'b10, 32'h6, 32'h87654321);
      load(32'h4);
      load(32'h6);

      // Reset priority over a coincident store
      store(2'b10, 32'h4, 32'h13579BDF);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'b10, 32'h4, 32'hFFFFFFFF);
      load(32'h4);
      load(32'h20);

      // Randomised traffic concentrated on a small window so stores and loads collide
      for (int i = 0; i < 400; i++) begin
         a = 32'($urandom_range(0, 47));
         if ($urandom_range(0, 3) == 0) a = $urandom;
         if ($urandom_range(0, 5) == 0) a = 32'(248 + $urandom_range(0, 7));
         s = 2'($urandom_range(0, 3));
         r = $urandom_range(0, 99);
         applyStimulus(r == 0, $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1, s, a, $urandom);
      end

      @(posedge clk);
      #1;
      rst = 1'b0; en = 1'b0; write = 1'b0;
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         checkCount++;
         $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
